// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory port.
// The slave modport is the arbiter's view; master is the view of the surrounding system.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              read_a;
  logic [ADDR_W-1:0] address_a;
  logic [31:0]       rdata_a;
  logic              resp_a;

  logic              read_b;
  logic              write_b;
  logic [ADDR_W-1:0] address_b;
  logic [31:0]       wdata_b;
  logic [3:0]        wmask_b;
  logic [31:0]       rdata_b;
  logic              resp_b;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_rdata;
  logic              mem_resp;

  modport slave (
    input  read_a, address_a, read_b, write_b, address_b, wdata_b, wmask_b,
    input  mem_rdata, mem_resp,
    output rdata_a, resp_a, rdata_b, resp_b,
    output mem_read, mem_write, mem_address, mem_wdata, mem_wmask
  );

  modport master (
    output read_a, address_a, read_b, write_b, address_b, wdata_b, wmask_b,
    output mem_rdata, mem_resp,
    input  rdata_a, resp_a, rdata_b, resp_b,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction (A, read-only)
// and a data (B, read/write) requester, with a no-response watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                timeout_err,
  output logic                proto_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  state_t            state_reg, state_next;
  logic              last_b_reg, last_b_next;
  logic [CNT_W-1:0]  wd_cnt_reg;
  logic              timeout_reg;
  logic              proto_reg;
  logic              proto_set;

  logic              mem_read_c, mem_write_c, resp_a_c, resp_b_c, busy_c;
  logic [ADDR_W-1:0] mem_address_c;
  logic [31:0]       mem_wdata_c, rdata_a_c, rdata_b_c;
  logic [3:0]        mem_wmask_c;
  logic              pend_a, pend_b;

  assign pend_a = bus.read_a;
  assign pend_b = bus.read_b | bus.write_b;

  // Everything is forced low while rst is asserted, whatever state is held.
  always_comb begin
    state_next    = state_reg;
    last_b_next   = last_b_reg;
    proto_set     = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    mem_address_c = '0;
    mem_wdata_c   = '0;
    mem_wmask_c   = '0;
    resp_a_c      = 1'b0;
    resp_b_c      = 1'b0;
    rdata_a_c     = '0;
    rdata_b_c     = '0;
    busy_c        = 1'b0;
    if (rst) begin
      case (state_reg)
        IDLE: begin
          proto_set = bus.read_b & bus.write_b;
          if (pend_a && pend_b) state_next = last_b_reg ? SERVE_A : SERVE_B;
          else if (pend_a)      state_next = SERVE_A;
          else if (pend_b)      state_next = SERVE_B;
        end
        SERVE_A: begin
          busy_c        = 1'b1;
          mem_read_c    = 1'b1;
          mem_address_c = bus.address_a;
          if (bus.mem_resp) begin
            resp_a_c    = 1'b1;
            rdata_a_c   = bus.mem_rdata;
            last_b_next = 1'b0;
            state_next  = IDLE;
          end
        end
        SERVE_B: begin
          busy_c        = 1'b1;
          // A simultaneous read+write is resolved as a read.
          mem_read_c    = bus.read_b;
          mem_write_c   = bus.write_b & ~bus.read_b;
          mem_address_c = bus.address_b;
          mem_wdata_c   = bus.wdata_b;
          mem_wmask_c   = bus.wmask_b;
          if (bus.mem_resp) begin
            resp_b_c    = 1'b1;
            rdata_b_c   = bus.mem_rdata;
            last_b_next = 1'b1;
            state_next  = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      last_b_reg  <= 1'b1;
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
      proto_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      last_b_reg <= last_b_next;
      if (proto_set) proto_reg <= 1'b1;
      if (state_reg == IDLE || bus.mem_resp)
        wd_cnt_reg <= '0;
      else if (wd_cnt_reg != WD_LAST)
        wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
      // Flag only; the transaction keeps waiting for its response.
      if (TIMEOUT > 0 && state_reg != IDLE && !bus.mem_resp && wd_cnt_reg == WD_LAST)
        timeout_reg <= 1'b1;
    end
  end

  assign bus.mem_read    = mem_read_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.mem_address = mem_address_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.mem_wmask   = mem_wmask_c;
  assign bus.resp_a      = resp_a_c;
  assign bus.rdata_a     = rdata_a_c;
  assign bus.resp_b      = resp_b_c;
  assign bus.rdata_b     = rdata_b_c;
  assign busy            = busy_c;
  assign timeout_err     = rst & timeout_reg;
  assign proto_err       = rst & proto_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized transaction rounds against a transaction-level model of
// the arbiter (pending flags, round-robin pointer, sticky error flags).
module tb_mem_port_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy, timeout_err, proto_err;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .timeout_err(timeout_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // model state
  logic        pend_a, pend_b, b_rd, b_wr, last_b, exp_to, exp_proto;
  logic [31:0] a_addr, b_addr, b_wdata;
  logic [3:0]  b_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic hold_a);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      rst = 1'b0; bus.read_a = hold_a; bus.address_a = a_addr;
      bus.read_b = 1'b0; bus.write_b = 1'b0;
      bus.mem_resp = 1'($urandom_range(0, 1)); bus.mem_rdata = $urandom;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 0);       chk("rst_mem_read", 64'(bus.mem_read), 0);
      chk("rst_mem_write", 64'(bus.mem_write), 0); chk("rst_mem_addr", 64'(bus.mem_address), 0);
      chk("rst_resp_a", 64'(bus.resp_a), 0); chk("rst_resp_b", 64'(bus.resp_b), 0);
      chk("rst_rdata_a", 64'(bus.rdata_a), 0); chk("rst_rdata_b", 64'(bus.rdata_b), 0);
      chk("rst_timeout", 64'(timeout_err), 0); chk("rst_proto", 64'(proto_err), 0);
    end
    pend_a = hold_a; pend_b = 1'b0; last_b = 1'b1; exp_to = 1'b0; exp_proto = 1'b0;
  endtask

  task automatic new_a();
    pend_a = 1'b1; a_addr = $urandom;
  endtask

  task automatic new_b();
    pend_b = 1'b1; b_rd = 1'($urandom_range(0, 1)); b_wr = ~b_rd;
    b_addr = $urandom; b_wdata = $urandom; b_mask = 4'($urandom);
  endtask

  // One idle (arbitration) cycle, then the granted transaction with mem_resp on cycle lat.
  task automatic round(input int lat, input logic [31:0] rd, input logic idle_resp);
    int w;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.read_a = pend_a; bus.address_a = a_addr;
    bus.read_b = pend_b & b_rd; bus.write_b = pend_b & b_wr;
    bus.address_b = b_addr; bus.wdata_b = b_wdata; bus.wmask_b = b_mask;
    bus.mem_resp = idle_resp; bus.mem_rdata = $urandom;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_mem_read", 64'(bus.mem_read), 0);
    chk("idle_mem_write", 64'(bus.mem_write), 0);
    chk("idle_resp_a", 64'(bus.resp_a), 0);
    chk("idle_resp_b", 64'(bus.resp_b), 0);
    chk("idle_rdata_a", 64'(bus.rdata_a), 0);
    chk("idle_timeout", 64'(timeout_err), 64'(exp_to));
    chk("idle_proto", 64'(proto_err), 64'(exp_proto));
    if (pend_a && pend_b) w = last_b ? 1 : 2;
    else if (pend_a)      w = 1;
    else if (pend_b)      w = 2;
    else                  w = 0;
    if (pend_b && b_rd && b_wr) exp_proto = 1'b1;
    if (w == 0) return;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      bus.mem_resp = (k == lat); bus.mem_rdata = (k == lat) ? rd : $urandom;
      @(negedge clk);
      chk("srv_busy", 64'(busy), 1);
      chk("srv_mem_read", 64'(bus.mem_read), (w == 1) ? 64'd1 : 64'(b_rd));
      chk("srv_mem_write", 64'(bus.mem_write), (w == 1) ? 64'd0 : 64'(b_wr & ~b_rd));
      chk("srv_mem_addr", 64'(bus.mem_address), (w == 1) ? 64'(a_addr) : 64'(b_addr));
      chk("srv_mem_wmask", 64'(bus.mem_wmask), (w == 1) ? 64'd0 : 64'(b_mask));
      if (w == 2) chk("srv_mem_wdata", 64'(bus.mem_wdata), 64'(b_wdata));
      chk("srv_resp_a", 64'(bus.resp_a), 64'(w == 1 && k == lat));
      chk("srv_resp_b", 64'(bus.resp_b), 64'(w == 2 && k == lat));
      chk("srv_rdata_a", 64'(bus.rdata_a), (w == 1 && k == lat) ? 64'(rd) : 64'd0);
      chk("srv_rdata_b", 64'(bus.rdata_b), (w == 2 && k == lat) ? 64'(rd) : 64'd0);
      chk("srv_timeout", 64'(timeout_err), 64'(exp_to || (k > TO)));
      chk("srv_proto", 64'(proto_err), 64'(exp_proto));
    end
    if (lat > TO) exp_to = 1'b1;
    if (w == 1) pend_a = 1'b0; else pend_b = 1'b0;
    last_b = (w == 2);
  endtask

  initial begin
    rst = 1'b0;
    bus.read_a = 0; bus.address_a = 0; bus.read_b = 0; bus.write_b = 0;
    bus.address_b = 0; bus.wdata_b = 0; bus.wmask_b = 0; bus.mem_rdata = 0; bus.mem_resp = 0;
    pend_a = 0; pend_b = 0; b_rd = 0; b_wr = 0; last_b = 1; exp_to = 0; exp_proto = 0;
    a_addr = 32'h60; b_addr = 0; b_wdata = 0; b_mask = 0;

    // reset held with read_a high, then a 3-cycle read of 0x60
    do_reset(1'b1);
    round(3, 32'hDEADBEEF, 1'b0);
    round(1, 32'h0, 1'b1);

    // simultaneous A read and B write, then continuous re-requests
    do_reset(1'b0);
    new_a();
    pend_b = 1; b_rd = 0; b_wr = 1; b_addr = 32'h100; b_wdata = 32'h12345678; b_mask = 4'b0011;
    for (int t = 0; t < 6; t++) begin
      if (!pend_a) new_a();
      if (!pend_b) new_b();
      round($urandom_range(1, 4), $urandom, 1'b0);
    end

    // watchdog: resp exactly at the limit, then a late resp after expiry
    new_a(); round(TO, $urandom, 1'b0);
    new_b(); round(TO + 4, $urandom, 1'b0);
    round(1, 32'h0, 1'b0);

    // reset in the middle of a transaction, stray mem_resp afterwards
    new_a(); round(1, $urandom, 1'b0);
    new_b();
    @(posedge clk); #1; rst = 1'b1; bus.read_a = 0;
    bus.read_b = b_rd; bus.write_b = b_wr; bus.address_b = b_addr;
    bus.wdata_b = b_wdata; bus.wmask_b = b_mask; bus.mem_resp = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 1);
    do_reset(1'b0);
    round(1, 32'h0, 1'b1);

    // read_b and write_b together
    pend_b = 1; b_rd = 1; b_wr = 1; b_addr = $urandom; b_wdata = $urandom; b_mask = 4'hF;
    round(2, $urandom, 1'b0);
    round(1, 32'h0, 1'b0);
    do_reset(1'b0);
    round(1, 32'h0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      if (!pend_a && $urandom_range(0, 2) != 0) new_a();
      if (!pend_b && $urandom_range(0, 2) != 0) new_b();
      round($urandom_range(1, 5), $urandom, 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
